// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I pipeline control logic.
package core_pkg;

    localparam int unsigned REG_SIZE = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    // Canned control words for each pipeline action
    localparam pipe_ctrl_t CTRL_RESET = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1, id_ex_en: 1'b0,
        id_ex_flush: 1'b1, ex_mem_en: 1'b0, mem_wb_flush: 1'b1
    };
    localparam pipe_ctrl_t CTRL_FREEZE = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b0,
        id_ex_flush: 1'b0, ex_mem_en: 1'b0, mem_wb_flush: 1'b1
    };
    localparam pipe_ctrl_t CTRL_REDIRECT = '{
        pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1, id_ex_en: 1'b1,
        id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_flush: 1'b0
    };
    localparam pipe_ctrl_t CTRL_BUBBLE = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b1,
        id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_flush: 1'b0
    };
    localparam pipe_ctrl_t CTRL_RUN = '{
        pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
        id_ex_flush: 1'b0, ex_mem_en: 1'b1, mem_wb_flush: 1'b0
    };

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID source register produced by a load in EX.
module hazard_detect #(
    parameter int unsigned REG_SIZE = 5
) (
    input  logic [REG_SIZE-1:0] id_rs1,
    input  logic [REG_SIZE-1:0] id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic                ex_memRead,
    input  logic [REG_SIZE-1:0] ex_rd,
    output logic                lu_hazard_c
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign rs1_hit     = id_use_rs1 && (ex_rd == id_rs1);
    assign rs2_hit     = id_use_rs2 && (ex_rd == id_rs2);
    assign lu_hazard_c = ex_memRead && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline stall/flush controller: load-use bubbles, redirect flushes, memory-wait freeze with watchdog.
module hazard_stall_unit #(
    parameter int unsigned REG_SIZE    = core_pkg::REG_SIZE,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_SIZE-1:0]  id_rs1,
    input  logic [REG_SIZE-1:0]  id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic                 ex_memRead,
    input  logic [REG_SIZE-1:0]  ex_rd,
    input  logic                 ex_redirect,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 if_id_flush,
    output logic                 id_ex_en,
    output logic                 id_ex_flush,
    output logic                 ex_mem_en,
    output logic                 mem_wb_flush,
    output logic                 mem_err,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    import core_pkg::*;

    localparam int unsigned WAIT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam bit          WD_ON  = (MEM_TIMEOUT != 0);

    hz_state_t          state;
    hz_state_t          state_nxt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [WAIT_W-1:0]  wait_cnt_nxt;
    logic               mem_err_q;
    logic               mem_err_nxt;
    logic               lu_hazard;
    logic               mem_stall;
    logic               wd_expired;
    logic               stall_inc;
    pipe_ctrl_t         ctrl;

    hazard_detect #(
        .REG_SIZE (REG_SIZE)
    ) u_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_memRead  (ex_memRead),
        .ex_rd       (ex_rd),
        .lu_hazard_c (lu_hazard)
    );

    assign mem_stall  = mem_req && !mem_ready;
    assign wd_expired = WD_ON && (wait_cnt == WAIT_W'(MEM_TIMEOUT));

    // Next state plus zero-latency control word; reset overrides everything
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_err_nxt  = mem_err_q;
        ctrl         = CTRL_RUN;

        case (state)
            RUN, MEM_WAIT: begin
                if (mem_stall) begin
                    ctrl = CTRL_FREEZE;
                    if (state == RUN) begin
                        state_nxt    = MEM_WAIT;
                        wait_cnt_nxt = WAIT_W'(1);
                    end else if (wd_expired) begin
                        state_nxt   = HALT;
                        mem_err_nxt = 1'b1;
                    end else begin
                        wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                    end
                end else begin
                    if (state == MEM_WAIT) begin
                        state_nxt    = RUN;
                        wait_cnt_nxt = '0;
                    end
                    if (ex_redirect) begin
                        ctrl = CTRL_REDIRECT;
                    end else if (lu_hazard) begin
                        ctrl = CTRL_BUBBLE;
                    end
                end
            end
            HALT: begin
                ctrl = CTRL_FREEZE;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase

        if (rst) begin
            ctrl = CTRL_RESET;
        end
    end

    assign stall_inc = !ctrl.pc_en && (state != HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_err_q    <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            mem_err_q <= mem_err_nxt;
            // Performance counter sticks at all-ones instead of wrapping
            if (stall_inc && !(&stall_cycles)) begin
                stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            end
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign if_id_en     = ctrl.if_id_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_en     = ctrl.id_ex_en;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_en    = ctrl.ex_mem_en;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign mem_err      = mem_err_q && !rst;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit with a short watchdog and narrow stall counter.
module tb_hazard_stall_unit;

    localparam int unsigned RW = 5;
    localparam int unsigned CW = 4;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_memRead, ex_redirect, mem_req, mem_ready;
    logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;
    logic          mem_err;
    logic [CW-1:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_stall_unit #(
        .REG_SIZE    (RW),
        .MEM_TIMEOUT (TO),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_memRead   (ex_memRead),
        .ex_rd        (ex_rd),
        .ex_redirect  (ex_redirect),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_ex_en     (id_ex_en),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_flush (mem_wb_flush),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles)
    );

    // ctrl bit order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush
    typedef struct packed {
        logic [6:0]    ctrl;
        logic          err;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    int   m_state = 0;  // 0 run, 1 mem wait, 2 halt
    int   m_wait  = 0;
    int   m_cnt   = 0;
    bit   m_err   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic exp_t model_out();
        exp_t e;
        logic lu, ms;
        lu = ex_memRead && (ex_rd != 0) &&
             ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
        ms = mem_req && !mem_ready;
        e.err = m_err;
        e.cnt = CW'(m_cnt);
        if (rst) begin
            e.ctrl = 7'b0010101;
            e.err  = 1'b0;
        end else if (m_state == 2 || ms) e.ctrl = 7'b0000001;
        else if (ex_redirect)            e.ctrl = 7'b1111110;
        else if (lu)                     e.ctrl = 7'b0001110;
        else                             e.ctrl = 7'b1101010;
        return e;
    endfunction

    task automatic model_edge(input logic pc);
        logic ms;
        ms = mem_req && !mem_ready;
        if (rst) begin
            m_state = 0; m_wait = 0; m_cnt = 0; m_err = 1'b0;
            return;
        end
        if (!pc && m_state != 2 && m_cnt < (1 << CW) - 1) m_cnt++;
        if (m_state == 0 && ms) begin
            m_state = 1; m_wait = 1;
        end else if (m_state == 1) begin
            if (!ms) begin
                m_state = 0; m_wait = 0;
            end else if (m_wait == TO) begin
                m_state = 2; m_err = 1'b1;
            end else begin
                m_wait++;
            end
        end
    endtask

    task automatic drive(input string tag, input logic r,
                         input logic [RW-1:0] rs1, input logic u1,
                         input logic [RW-1:0] rs2, input logic u2,
                         input logic ld, input logic [RW-1:0] rd,
                         input logic redir, input logic mq, input logic mr);
        exp_t e;
        rst = r; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        ex_memRead = ld; ex_rd = rd; ex_redirect = redir; mem_req = mq; mem_ready = mr;
        sb_q.push_back(model_out());
        @(negedge clk);
        e = sb_q.pop_front();
        check({tag, "_ctrl"}, 32'({pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                                   ex_mem_en, mem_wb_flush}), 32'(e.ctrl));
        check({tag, "_err"}, 32'(mem_err), 32'(e.err));
        check({tag, "_cnt"}, 32'(stall_cycles), 32'(e.cnt));
        @(posedge clk);
        model_edge(e.ctrl[6]);
        #1;
    endtask

    task automatic idle(input string tag);
        drive(tag, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_memRead = 1'b0; ex_rd = '0; ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;

        drive("rst", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        drive("rst", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);

        // Single load-use bubble
        drive("lu", 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        drive("lu_next", 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("lu_cnt", 32'(stall_cycles), 32'd1);

        // Non-hazards: load to x0, unused rs2 match, ready without request
        drive("ld_x0", 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        drive("rs2_unused", 1'b0, 5'd3, 1'b1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        drive("rs2_used", 1'b0, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        drive("rdy_noreq", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        drive("redir_lu", 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        check("redir_cnt", 32'(stall_cycles), 32'd2);

        // Memory wait with a pending redirect
        drive("rst2", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            drive("mw", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        drive("mw_rel", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        idle("mw_idle");
        check("mw_cnt", 32'(stall_cycles), 32'd3);

        // Watchdog trips after TO wait cycles and holds through mem_ready
        for (int i = 0; i < 5; i++)
            drive("wd", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("wd_err", 32'(mem_err), 32'd1);
        drive("halt", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        drive("halt", 1'b0, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
        check("halt_cnt", 32'(stall_cycles), 32'd8);
        drive("wd_rst", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        idle("post_rst");
        check("post_rst_err", 32'(mem_err), 32'd0);

        // Counter saturation
        for (int i = 0; i < 20; i++)
            drive("sat", 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        idle("sat_idle");
        check("sat_cnt", 32'(stall_cycles), 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
